lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
- Sequences every LB/LH/LW/LBU/LHU/SB/SH/SW between the femtoRV32 core and the word-wide data memory.
- Accepts one request per transaction from the execute stage and issues one or two aligned word accesses with byte enables. Misaligned accesses are split into two.
- For loads, assembles the returned bytes and applies sign or zero extension; for all requests, returns a single completion pulse.
- The core stalls on req_ready low.

Parameters:
- SPLIT_EN, 1: 1 = split misaligned accesses into two word accesses; 0 = flag misaligned accesses as errors with no memory access.
- WAIT_MAX, 255: maximum cycles mem_req may stay unacknowledged before the transaction aborts with error. Range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 half, 10 byte, 11 illegal. Same encoding as the CU instruction-select field.
- req_signed  in  1  1 = sign-extend load result; ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: illegal size, misaligned with SPLIT_EN=0, or timeout.
- mem_req  out  1  memory access request, held until mem_ack.
- mem_ack  in  1  memory accepted the access; for reads, mem_rdata is valid in this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  30  word address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - req_ready=1 once in IDLE; all other outputs 0, including mem_req, resp_valid, resp_rdata, resp_err, mem_be, mem_addr and mem_wdata.
  - Reset asserted mid-transaction drops mem_req immediately, discards the transaction and emits no response.
- States: IDLE, ACC1, ACC2, RESP.
- IDLE:
  - A request is accepted on req_valid && req_ready. All request fields are captured, along with offset=addr[1:0] and n bytes (4/2/1).
  - Misaligned means offset+n>4.
  - Go to RESP with err=1 (no memory access) if size=11, or if the access is misaligned and SPLIT_EN=0.
  - Otherwise go to ACC1.
- Lane computation:
  - mask64 = ((1<<n)-1) << offset.
  - wdata64 = req_wdata << (8*offset).
  - Beat 1: mem_addr = addr[31:2], mem_be = mask64[3:0], mem_wdata = wdata64[31:0].
  - Beat 2: mem_addr = addr[31:2]+1, wrapping modulo 2^30 (address 0xFFFFFFFF wraps to word 0), mem_be = mask64[7:4], mem_wdata = wdata64[63:32].
  - mem_wdata bytes whose enable is 0 are driven 0.
- ACC1 / ACC2:
  - mem_req=1, registered, starting the cycle after entry.
  - Address, be, we and wdata stay stable until mem_ack.
  - On mem_ack, a load captures mem_rdata into the low word (ACC1) or high word (ACC2) of a 64-bit buffer.
  - ACC1 with mem_ack goes to ACC2 if misaligned, else to RESP.
  - ACC2 with mem_ack goes to RESP.
  - mem_req is low for at least one cycle between beats.
- Timeout:
  - A wait counter resets on entry to each ACC state and counts cycles with mem_req=1 && !mem_ack.
  - When it reaches WAIT_MAX: drop mem_req, go to RESP with err=1, and skip any second beat.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE. req_ready=0 during RESP.
  - Load data: shifted = buffer64 >> (8*offset). Take the low n bytes. If req_signed and n<4, sign-extend from bit 8n-1; otherwise zero-extend.
- Latency, with request accepted at cycle T:
  - mem_req rises at T+1.
  - With immediate ack, aligned: resp_valid at T+2.
  - With immediate ack, split: ack1 at T+1, mem_req low at T+2, beat-2 request at T+3, resp_valid at T+4.
  - Error without access: resp_valid at T+1.
- A store with size=00 and signed=1 behaves as a word store; req_signed is ignored for stores.
- req_valid seen while req_ready=0 is ignored; the core holds its request.

Test Plan:
- LW at addr 0x100, mem_rdata 0xDEADBEEF, ack at first mem_req cycle -> mem_addr=0x40, be=1111, resp_rdata=0xDEADBEEF, err=0, resp_valid exactly 2 cycles after accept.
- LB signed at 0x103, rdata 0x80FF_FF00 -> be=1000, resp_rdata=0xFFFFFF80; the same request as LBU -> 0x00000080.
- SH at 0x203, wdata 0x0000ABCD, SPLIT_EN=1 -> beat1: addr 0x80, be=1000, wdata=0xCD000000; beat2: addr 0x81, be=0001, wdata=0x000000AB; one resp_valid, err=0.
- LW at 0xFFFFFFFE, words 0x11223344 then 0x55667788 -> beat addrs 0x3FFFFFFF then 0x00000000; resp_rdata=0x77881122.
- size=11, and with SPLIT_EN=0 an LW at 0x001 -> no mem_req ever; resp_valid the cycle after accept with err=1, rdata=0.
- WAIT_MAX=4, mem_ack held low -> mem_req high for exactly 4 cycles then low, resp err=1. Separately, rst_n pulsed low mid-ACC2 -> mem_req low immediately, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_sequencer
//  Purpose  : Load/store sequencer between the femtoRV32 execute stage and a
//             word-wide data memory. Each byte/half/word request is turned
//             into one aligned word access, or two when it straddles a word
//             boundary. Loads are reassembled and sign/zero extended. Every
//             request produces exactly one completion pulse.
//  Ports    : clk, rst_n                      - clock, async active-low reset
//             req_valid/req_ready             - request handshake (ready only
//                                               when idle)
//             req_we/size/signed/addr/wdata   - request fields
//             resp_valid/resp_rdata/resp_err  - one-cycle completion
//             mem_req/mem_ack                 - memory handshake
//             mem_we/addr/be/wdata/rdata      - word-wide memory bus
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_sequencer #(
    parameter int SPLIT_EN = 1,
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_ACC1      = 2'd1;
    localparam logic [1:0]  c_ACC2      = 2'd2;
    localparam logic [1:0]  c_RESP      = 2'd3;
    localparam logic [15:0] c_WAIT_LAST = 16'(WAIT_MAX - 1);

    logic [1:0]  r_state;
    logic        r_we;
    logic        r_signed;
    logic [2:0]  r_n;
    logic [1:0]  r_offset;
    logic [29:0] r_word;
    logic [31:0] r_wdata;
    logic        r_misal;
    logic        r_err;
    logic        r_mem_req;
    logic [15:0] r_wait;
    logic [63:0] r_buf;

    // ------------------------------------------------------------------
    // Request decode (used only at acceptance)
    // ------------------------------------------------------------------
    logic [2:0] w_n_in;
    logic       w_misal_in;
    logic       w_bad_in;

    always_comb begin
        w_n_in = 3'd4;
        case (req_size)
            2'b01:   w_n_in = 3'd2;
            2'b10:   w_n_in = 3'd1;
            default: w_n_in = 3'd4;
        endcase
    end

    assign w_misal_in = ({2'b00, req_addr[1:0]} + {1'b0, w_n_in}) > 4'd4;
    assign w_bad_in   = (req_size == 2'b11) || (w_misal_in && (SPLIT_EN == 0));

    // ------------------------------------------------------------------
    // Lane placement over a two-word window: low word is beat 1, high
    // word is beat 2.
    // ------------------------------------------------------------------
    logic [7:0]  w_ones;
    logic [7:0]  w_mask64;
    logic [63:0] w_wdata64;
    logic [63:0] w_wd_masked;

    assign w_ones    = (8'd1 << r_n) - 8'd1;
    assign w_mask64  = w_ones << r_offset;
    assign w_wdata64 = {32'h0, r_wdata} << {r_offset, 3'b000};

    // Disabled byte lanes are driven to zero.
    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign w_wd_masked[8*g +: 8] = w_mask64[g] ? w_wdata64[8*g +: 8] : 8'h00;
    end

    logic w_beat2;
    assign w_beat2 = (r_state == c_ACC2);

    // Bus fields are only non-zero while a request is outstanding; the
    // captured request keeps them stable until mem_ack.
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_req & r_we;
    assign mem_addr  = r_mem_req ? (w_beat2 ? r_word + 30'd1 : r_word) : 30'd0;
    assign mem_be    = r_mem_req ? (w_beat2 ? w_mask64[7:4] : w_mask64[3:0]) : 4'h0;
    assign mem_wdata = r_mem_req ? (w_beat2 ? w_wd_masked[63:32] : w_wd_masked[31:0]) : 32'h0;

    // ------------------------------------------------------------------
    // Load result: shift the collected bytes down to bit 0 and extend.
    // ------------------------------------------------------------------
    logic [31:0] w_shift;
    logic [31:0] w_ext;

    assign w_shift = 32'(r_buf >> {r_offset, 3'b000});

    always_comb begin
        w_ext = w_shift;
        case (r_n)
            3'd1:    w_ext = {{24{r_signed & w_shift[7]}},  w_shift[7:0]};
            3'd2:    w_ext = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    assign req_ready  = (r_state == c_IDLE);
    assign resp_valid = (r_state == c_RESP);
    assign resp_err   = (r_state == c_RESP) & r_err;
    assign resp_rdata = ((r_state == c_RESP) && !r_err && !r_we) ? w_ext : 32'h0;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_we      <= 1'b0;
            r_signed  <= 1'b0;
            r_n       <= 3'd0;
            r_offset  <= 2'd0;
            r_word    <= 30'd0;
            r_wdata   <= 32'h0;
            r_misal   <= 1'b0;
            r_err     <= 1'b0;
            r_mem_req <= 1'b0;
            r_wait    <= 16'd0;
            r_buf     <= 64'h0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_signed <= req_signed;
                        r_n      <= w_n_in;
                        r_offset <= req_addr[1:0];
                        r_word   <= req_addr[31:2];
                        r_wdata  <= req_wdata;
                        r_misal  <= w_misal_in;
                        r_buf    <= 64'h0;
                        r_wait   <= 16'd0;
                        if (w_bad_in) begin
                            r_err   <= 1'b1;
                            r_state <= c_RESP;
                        end else begin
                            r_err     <= 1'b0;
                            r_mem_req <= 1'b1;
                            r_state   <= c_ACC1;
                        end
                    end
                end

                c_ACC1, c_ACC2: begin
                    if (r_mem_req) begin
                        if (mem_ack) begin
                            r_mem_req <= 1'b0;
                            r_wait    <= 16'd0;
                            if (!r_we) begin
                                if (w_beat2) begin
                                    r_buf[63:32] <= mem_rdata;
                                end else begin
                                    r_buf[31:0] <= mem_rdata;
                                end
                            end
                            if (!w_beat2 && r_misal) begin
                                r_state <= c_ACC2;
                            end else begin
                                r_state <= c_RESP;
                            end
                        end else if (r_wait == c_WAIT_LAST) begin
                            // Timed out: abandon the access, including any
                            // second beat still to come.
                            r_mem_req <= 1'b0;
                            r_err     <= 1'b1;
                            r_state   <= c_RESP;
                        end else begin
                            r_wait <= r_wait + 16'd1;
                        end
                    end else begin
                        // First cycle of beat 2: mem_req was dropped for one
                        // cycle after beat 1's ack, raise it again now.
                        r_mem_req <= 1'b1;
                    end
                end

                c_RESP: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_sequencer
//  Purpose  : Self-checking bench for lsu_sequencer. Instance A splits
//             misaligned accesses, instance B flags them. Both use a short
//             wait limit so timeouts are quick to reach. Expected values come
//             from a byte-by-byte model of memory and a cycle timeline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_sequencer;

    localparam int WAIT_A = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A (SPLIT_EN=1)
    logic        req_valid, req_we, req_signed, mem_ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;

    // Instance B (SPLIT_EN=0)
    logic        b_req_valid, b_req_we, b_req_signed, b_mem_ack;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata, b_mem_rdata;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req, b_mem_we;
    logic [31:0] b_resp_rdata, b_mem_wdata;
    logic [29:0] b_mem_addr;
    logic [3:0]  b_mem_be;

    lsu_sequencer #(.SPLIT_EN(1), .WAIT_MAX(WAIT_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_sequencer #(.SPLIT_EN(0), .WAIT_MAX(WAIT_A)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .mem_req(b_mem_req), .mem_ack(b_mem_ack), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Sparse word memory shared by the responder and the reference model.
    bit [31:0] mem [bit [29:0]];

    // Observations of the most recent run_txn.
    int          obs_cyc, obs_nb;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic [29:0] obs_addr [4];
    logic [3:0]  obs_be   [4];
    logic [31:0] obs_wd   [4];
    logic        obs_we   [4];
    int          obs_hi   [4];

    // ------------------------------------------------------------------
    // One transaction on instance A. d1/d2 = cycles of mem_req before the
    // bench acks beat 1/2; a delay >= WAIT_A never gets acked.
    // ------------------------------------------------------------------
    task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int d1, input int d2, input string tag);
        int          n, nb, start, exp_cyc, cyc, hi, d;
        logic [29:0] e_addr [4];
        logic [3:0]  e_be   [4];
        logic [31:0] e_wd   [4];
        int          e_hi   [4];
        logic        e_err, tmo, prev_req, prev_ack, ack_now, done, bad_ready, unstable;
        logic [31:0] e_rdata, a, word;

        n  = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            e_addr[i] = '0; e_be[i] = '0; e_wd[i] = '0; e_hi[i] = 0;
        end
        // Walk the bytes of the access; each new word address is a new beat.
        if (size != 2'b11) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
                if (nb == 0 || e_addr[nb-1] != a[31:2]) begin
                    e_addr[nb] = a[31:2];
                    nb++;
                end
                e_be[nb-1][a[1:0]] = 1'b1;
                e_wd[nb-1][8*a[1:0] +: 8] = wdata[8*i +: 8];
            end
        end
        // Timeline: beat starts at 'start', acked at start+d, next beat
        // starts two cycles after the ack, response one cycle after the last.
        tmo = 1'b0; exp_cyc = 1; start = 1;
        for (int b = 0; b < nb; b++) begin
            d = (b == 0) ? d1 : d2;
            if (d >= WAIT_A) begin
                e_hi[b] = WAIT_A;
                exp_cyc = start + WAIT_A;
                tmo     = 1'b1;
                nb      = b + 1;
                break;
            end
            e_hi[b] = d + 1;
            exp_cyc = start + d + 1;
            start   = start + d + 2;
        end
        e_err   = (size == 2'b11) || tmo;
        e_rdata = 32'h0;
        if (!we && !e_err) begin
            for (int i = 0; i < n; i++) begin
                a    = addr + 32'(i);
                word = mem[a[31:2]];
                e_rdata[8*i +: 8] = word[8*a[1:0] +: 8];
            end
            if (sgn && n < 4 && e_rdata[8*n-1]) begin
                for (int i = 8*n; i < 32; i++) e_rdata[i] = 1'b1;
            end
        end

        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_idle: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;

        cyc = 0; done = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; hi = 0;
        bad_ready = 1'b0; unstable = 1'b0;
        obs_cyc = -1; obs_nb = 0; obs_rdata = 'x; obs_err = 1'bx;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            // Request fields change after acceptance; they must be ignored.
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
            req_size = 2'($urandom); req_we = 1'($urandom); req_signed = 1'($urandom);
            if (resp_valid === 1'b1) begin
                done = 1'b1; obs_cyc = cyc; obs_rdata = resp_rdata; obs_err = resp_err;
            end
            if (req_ready !== 1'b0) bad_ready = 1'b1;
            if (mem_req === 1'b1) begin
                if (!prev_req || prev_ack) begin
                    if (obs_nb < 4) begin
                        obs_addr[obs_nb] = mem_addr; obs_be[obs_nb] = mem_be;
                        obs_wd[obs_nb] = mem_wdata; obs_we[obs_nb] = mem_we;
                        obs_hi[obs_nb] = 0;
                    end
                    obs_nb++;
                    hi = 0;
                end else if (obs_nb <= 4) begin
                    if (mem_addr !== obs_addr[obs_nb-1] || mem_be !== obs_be[obs_nb-1] ||
                        mem_wdata !== obs_wd[obs_nb-1] || mem_we !== obs_we[obs_nb-1])
                        unstable = 1'b1;
                end
                hi++;
                if (obs_nb <= 4) obs_hi[obs_nb-1] = hi;
                d = (obs_nb == 1) ? d1 : d2;
                if (hi > d) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    ack_now = 1'b1;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom; ack_now = 1'b0;
                end
            end else begin
                mem_ack = 1'b0; ack_now = 1'b0;
            end
            prev_req = (mem_req === 1'b1);
            prev_ack = ack_now;
        end
        mem_ack = 1'b0;

        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s resp_missing: no resp_valid within %0d cycles", tag, cyc);
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_resp: resp_valid=%b req_ready=%b want 0 1", tag, resp_valid, req_ready);
        end
        n_cmp++;
        if (obs_cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", tag, obs_cyc, exp_cyc);
        end
        n_cmp++;
        if (obs_err !== e_err) begin
            n_fail++;
            $display("FAIL %s err: got %b want %b", tag, obs_err, e_err);
        end
        n_cmp++;
        if (obs_rdata !== e_rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", tag, obs_rdata, e_rdata);
        end
        n_cmp++;
        if (obs_nb != nb) begin
            n_fail++;
            $display("FAIL %s beats: got %0d want %0d", tag, obs_nb, nb);
        end
        for (int b = 0; b < nb && b < obs_nb && b < 4; b++) begin
            n_cmp++;
            if (obs_addr[b] !== e_addr[b] || obs_be[b] !== e_be[b] || obs_we[b] !== we ||
                obs_hi[b] != e_hi[b] || (we && obs_wd[b] !== e_wd[b])) begin
                n_fail++;
                $display("FAIL %s beat%0d: got addr=%h be=%b we=%b wd=%h hi=%0d want addr=%h be=%b we=%b wd=%h hi=%0d",
                         tag, b, obs_addr[b], obs_be[b], obs_we[b], obs_wd[b], obs_hi[b],
                         e_addr[b], e_be[b], we, e_wd[b], e_hi[b]);
            end
        end
        n_cmp++;
        if (bad_ready || unstable) begin
            n_fail++;
            $display("FAIL %s busy: ready_high=%b bus_unstable=%b want 0 0", tag, bad_ready, unstable);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b10000 ||
                resp_rdata !== 32'h0 || mem_be !== 4'h0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_a%0d: rdy=%b rv=%b err=%b req=%b we=%b rd=%h be=%b ad=%h wd=%h want 1 0 0 0 0 0 0 0 0",
                         k, req_ready, resp_valid, resp_err, mem_req, mem_we, resp_rdata, mem_be, mem_addr, mem_wdata);
            end
            n_cmp++;
            if ({b_req_ready, b_resp_valid, b_resp_err, b_mem_req, b_mem_we} !== 5'b10000 ||
                b_resp_rdata !== 32'h0 || b_mem_be !== 4'h0 || b_mem_addr !== 30'h0 || b_mem_wdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_b%0d: rdy=%b rv=%b err=%b req=%b we=%b rd=%h be=%b ad=%h wd=%h want 1 0 0 0 0 0 0 0 0",
                         k, b_req_ready, b_resp_valid, b_resp_err, b_mem_req, b_mem_we, b_resp_rdata, b_mem_be, b_mem_addr, b_mem_wdata);
            end
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_directed();
        mem[30'h40] = 32'hDEADBEEF;
        run_txn(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0, 0, "lw_100");
        n_cmp++;
        if (obs_cyc != 2 || obs_addr[0] !== 30'h40 || obs_be[0] !== 4'hF || obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL plan_lw: cyc=%0d addr=%h be=%b rd=%h err=%b want 2 040 1111 deadbeef 0",
                     obs_cyc, obs_addr[0], obs_be[0], obs_rdata, obs_err);
        end

        mem[30'h40] = 32'h80FFFF00;
        run_txn(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 0, 0, "lb_103");
        n_cmp++;
        if (obs_be[0] !== 4'b1000 || obs_rdata !== 32'hFFFFFF80) begin
            n_fail++;
            $display("FAIL plan_lb: be=%b rd=%h want 1000 ffffff80", obs_be[0], obs_rdata);
        end
        run_txn(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 1, 0, "lbu_103");
        n_cmp++;
        if (obs_rdata !== 32'h00000080) begin
            n_fail++;
            $display("FAIL plan_lbu: rd=%h want 00000080", obs_rdata);
        end

        run_txn(1'b1, 2'b01, 1'b0, 32'h203, 32'h0000ABCD, 0, 0, "sh_203");
        n_cmp++;
        if (obs_nb != 2 || obs_addr[0] !== 30'h80 || obs_be[0] !== 4'b1000 || obs_wd[0] !== 32'hCD000000 ||
            obs_addr[1] !== 30'h81 || obs_be[1] !== 4'b0001 || obs_wd[1] !== 32'h000000AB || obs_err !== 1'b0 || obs_cyc != 4) begin
            n_fail++;
            $display("FAIL plan_sh: nb=%0d %h/%b/%h %h/%b/%h err=%b cyc=%0d want 2 080/1000/cd000000 081/0001/000000ab 0 4",
                     obs_nb, obs_addr[0], obs_be[0], obs_wd[0], obs_addr[1], obs_be[1], obs_wd[1], obs_err, obs_cyc);
        end

        mem[30'h3FFFFFFF] = 32'h11223344;
        mem[30'h0]        = 32'h55667788;
        run_txn(1'b0, 2'b00, 1'b0, 32'hFFFFFFFE, 32'h0, 0, 0, "lw_wrap");
        n_cmp++;
        if (obs_addr[0] !== 30'h3FFFFFFF || obs_addr[1] !== 30'h0 || obs_rdata !== 32'h77881122) begin
            n_fail++;
            $display("FAIL plan_wrap: a0=%h a1=%h rd=%h want 3fffffff 0000000 77881122", obs_addr[0], obs_addr[1], obs_rdata);
        end

        run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 0, "size11");
        n_cmp++;
        if (obs_nb != 0 || obs_cyc != 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL plan_size11: nb=%0d cyc=%0d err=%b rd=%h want 0 1 1 0", obs_nb, obs_cyc, obs_err, obs_rdata);
        end

        run_txn(1'b1, 2'b00, 1'b1, 32'h300, 32'h12345678, 0, 0, "sw_signed");

        run_txn(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 100, 0, "timeout");
        n_cmp++;
        if (obs_hi[0] != 4 || obs_err !== 1'b1 || obs_cyc != 5) begin
            n_fail++;
            $display("FAIL plan_timeout: req_cycles=%0d err=%b cyc=%0d want 4 1 5", obs_hi[0], obs_err, obs_cyc);
        end
        run_txn(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1, 100, "timeout_beat2");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int t = 0; t < 80; t++) begin
            addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7))) : $urandom;
            run_txn(1'($urandom), ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                    1'($urandom), addr, $urandom,
                    ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3), "rand");
        end
    endtask

    // SPLIT_EN=0: misaligned and illegal requests fail without touching memory.
    task automatic test_split_off();
        logic [1:0]  sz;
        logic [31:0] ad, word, e_rd, orr;
        logic        e_err, saw_req, done, oerr;
        int          cyc, ocyc, e_cyc;
        for (int v = 0; v < 5; v++) begin
            case (v)
                0: begin sz = 2'b00; ad = 32'h001; e_err = 1'b1; end
                1: begin sz = 2'b11; ad = 32'h100; e_err = 1'b1; end
                2: begin sz = 2'b01; ad = 32'h503; e_err = 1'b1; end
                3: begin sz = 2'b01; ad = 32'h502; e_err = 1'b0; end
                default: begin sz = 2'b10; ad = 32'h503; e_err = 1'b0; end
            endcase
            word = $urandom | 32'h80808080;
            mem[ad[31:2]] = word;
            word = word >> (8 * ad[1:0]);
            e_rd = e_err ? 32'h0 : (sz == 2'b01) ? {{16{word[15]}}, word[15:0]} : {{24{word[7]}}, word[7:0]};
            e_cyc = e_err ? 1 : 2;

            @(negedge clk);
            b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = sz; b_req_signed = 1'b1;
            b_req_addr = ad; b_req_wdata = $urandom;
            cyc = 0; done = 1'b0; saw_req = 1'b0; ocyc = -1; orr = 'x; oerr = 1'bx;
            while (!done && cyc < 10) begin
                @(negedge clk);
                cyc++;
                b_req_valid = 1'b0;
                if (b_resp_valid === 1'b1) begin
                    done = 1'b1; ocyc = cyc; orr = b_resp_rdata; oerr = b_resp_err;
                end
                if (b_mem_req === 1'b1) begin
                    saw_req = 1'b1; b_mem_ack = 1'b1;
                    b_mem_rdata = mem.exists(b_mem_addr) ? mem[b_mem_addr] : 32'h0;
                end else begin
                    b_mem_ack = 1'b0;
                end
            end
            b_mem_ack = 1'b0;
            n_cmp++;
            if (ocyc != e_cyc || oerr !== e_err || orr !== e_rd || saw_req !== !e_err) begin
                n_fail++;
                $display("FAIL split_off%0d: cyc=%0d err=%b rd=%h memreq=%b want %0d %b %h %b",
                         v, ocyc, oerr, orr, saw_req, e_cyc, e_err, e_rd, !e_err);
            end
        end
    endtask

    // Reset asserted while beat 2 is outstanding.
    task automatic test_reset_mid();
        logic saw_resp;
        mem[30'h0] = 32'hA1B2C3D4;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h2;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = mem[30'h0];
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 30'h1) begin
            n_fail++;
            $display("FAIL rst_mid_beat2: mem_req=%b addr=%h want 1 0000001", mem_req, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_be !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_mid_drop: mem_req=%b be=%b want 0 0000", mem_req, mem_be);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_resp = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) saw_resp = 1'b1;
        end
        n_cmp++;
        if (saw_resp || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: resp_seen=%b req_ready=%b mem_req=%b want 0 1 0", saw_resp, req_ready, mem_req);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b00; b_req_signed = 1'b0;
        b_req_addr = 32'h0; b_req_wdata = 32'h0; b_mem_ack = 1'b0; b_mem_rdata = 32'h0;

        test_reset();
        test_directed();
        test_split_off();
        test_random();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
